// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fills a registered fetch slot,
// handles branch redirects, skips zero words and halts at the end of memory.
module fetch_sequencer #(
    parameter int          MEM_DEPTH  = 32,
    parameter logic [31:0] START_ADDR = 32'd0,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    output logic             if_valid,
    input  logic             id_ready,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic             busy,
    output logic             halt,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALT
    } state_t;

    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);
    localparam logic [31:0] LAST  = 32'(MEM_DEPTH - 1);

    state_t      state;
    logic [31:0] pc;
    logic        adv;
    logic        active;

    assign adv       = !if_valid || id_ready;
    assign active    = (state == FETCH) || (state == DRAIN);
    assign imem_addr = pc;
    assign busy      = active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= START_ADDR;
            if_instr    <= 32'd0;
            if_pc       <= 32'd0;
            if_valid    <= 1'b0;
            halt        <= 1'b0;
            fetch_count <= '0;
        end else if (active && redirect_valid) begin
            // Redirect beats stall: the slot is dropped even if decode is stalled
            if_valid <= 1'b0;
            pc       <= redirect_target;
            if (redirect_target < DEPTH) begin
                state <= FETCH;
            end else begin
                state <= HALT;
                halt  <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= FETCH;
                end
                FETCH: begin
                    if (adv) begin
                        if (imem_data != 32'd0) begin
                            if_instr    <= imem_data;
                            if_pc       <= pc;
                            if_valid    <= 1'b1;
                            fetch_count <= fetch_count + CNT_W'(1);
                        end else begin
                            if_valid <= 1'b0;
                        end
                        pc <= pc + 32'd1;
                        if (pc == LAST) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (adv) begin
                        state    <= HALT;
                        if_valid <= 1'b0;
                        halt     <= 1'b1;
                    end
                end
                HALT: begin
                    if_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural fetch model.
module tb_fetch_sequencer;

    localparam int DEPTH = 32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        busy;
    logic        halt;
    logic [15:0] fetch_count;

    logic [31:0] mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: phase 0 idle, 1 running, 2 waiting out the last word, 3 done
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    bit          m_valid;
    logic [15:0] m_cnt;

    fetch_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_valid        (if_valid),
        .id_ready        (id_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .busy            (busy),
        .halt            (halt),
        .fetch_count     (fetch_count)
    );

    assign imem_data = (imem_addr < DEPTH) ? mem[imem_addr[4:0]] : 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a < DEPTH) ? mem[a[4:0]] : 32'd0;
    endfunction

    task automatic model_step();
        bit free;
        logic [31:0] w;
        if (!rst_n) begin
            m_phase = 0;
            m_pc    = 32'd0;
            m_instr = 32'd0;
            m_ipc   = 32'd0;
            m_valid = 0;
            m_cnt   = 16'd0;
            return;
        end
        free = !m_valid || id_ready;
        if ((m_phase == 1 || m_phase == 2) && redirect_valid) begin
            m_valid = 0;
            m_pc    = redirect_target;
            m_phase = (redirect_target < DEPTH) ? 1 : 3;
        end else if (m_phase == 0) begin
            if (start) m_phase = 1;
        end else if (m_phase == 1) begin
            if (free) begin
                w = word_at(m_pc);
                if (w != 0) begin
                    m_instr = w;
                    m_ipc   = m_pc;
                    m_valid = 1;
                    m_cnt   = m_cnt + 16'd1;
                end else begin
                    m_valid = 0;
                end
                if (m_pc == DEPTH - 1) m_phase = 2;
                m_pc = m_pc + 32'd1;
            end
        end else if (m_phase == 2) begin
            if (free) begin
                m_phase = 3;
                m_valid = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("addr", imem_addr, m_pc);
        chk("valid", 32'(if_valid), 32'(m_valid));
        if (m_valid) begin
            chk("instr", if_instr, m_instr);
            chk("ipc", if_pc, m_ipc);
        end
        chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
        chk("halt", 32'(halt), 32'(m_phase == 3));
        chk("count", 32'(fetch_count), 32'(m_cnt));
    endtask

    // Inputs are held across the edge; the model advances with them
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    endtask

    int          n;
    int          xfers;
    logic [31:0] xpc;
    logic [31:0] xin;

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        clear_mem();

        // Single nonzero word, run to the end of memory
        mem[1]   = 32'h02000063;
        id_ready = 1'b1;
        do_reset();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        do_start();
        xfers = 0;
        xpc   = 32'hFFFF_FFFF;
        xin   = 32'd0;
        repeat (40) begin
            if (if_valid && id_ready) begin
                xfers++;
                xpc = if_pc;
                xin = if_instr;
            end
            cycle();
        end
        chk("t1_xfers", 32'(xfers), 32'd1);
        chk("t1_pc", xpc, 32'd1);
        chk("t1_instr", xin, 32'h02000063);
        chk("t1_count", 32'(fetch_count), 32'd1);
        chk("t1_halt", 32'(halt), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);

        // Back-pressure on the first word
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;
        id_ready = 1'b0;
        do_reset();
        do_start();
        cycle();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(if_valid), 32'd1);
            chk("t2_hold_pc", if_pc, 32'd0);
            chk("t2_hold_addr", imem_addr, 32'd1);
            cycle();
        end
        id_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            chk("t2_seq_pc", if_pc, 32'(k));
            chk("t2_seq_valid", 32'(if_valid), 32'd1);
        end

        // Redirect while stalled on if_pc=5
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000 + i;
        do_reset();
        do_start();
        n = 0;
        while (!(if_valid && if_pc == 32'd5) && n < 20) begin
            cycle();
            n++;
        end
        chk("t3_reach5", 32'(n < 20), 32'd1);
        id_ready        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'd2;
        cycle();
        redirect_valid = 1'b0;
        chk("t3_flush_valid", 32'(if_valid), 32'd0);
        chk("t3_flush_count", 32'(fetch_count), 32'd6);
        id_ready = 1'b1;
        cycle();
        chk("t3_tgt_pc", if_pc, 32'd2);
        chk("t3_tgt_valid", 32'(if_valid), 32'd1);
        chk("t3_tgt_count", 32'(fetch_count), 32'd7);

        // Out-of-range redirect halts
        redirect_valid  = 1'b1;
        redirect_target = 32'd40;
        cycle();
        redirect_valid = 1'b0;
        chk("t4_halt", 32'(halt), 32'd1);
        chk("t4_valid", 32'(if_valid), 32'd0);
        repeat (2) cycle();

        // Last word stalled in DRAIN
        do_reset();
        do_start();
        n = 0;
        while (!(if_valid && if_pc == 32'd31) && n < 50) begin
            cycle();
            n++;
        end
        chk("t5_reach31", 32'(n < 50), 32'd1);
        id_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("t5_stall_halt", 32'(halt), 32'd0);
            chk("t5_stall_pc", if_pc, 32'd31);
        end
        id_ready = 1'b1;
        cycle();
        chk("t5_halt", 32'(halt), 32'd1);

        // Reset in the middle of fetching
        do_reset();
        do_start();
        repeat (4) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("t6_valid", 32'(if_valid), 32'd0);
        chk("t6_addr", imem_addr, 32'd0);
        chk("t6_instr", if_instr, 32'd0);
        chk("t6_ipc", if_pc, 32'd0);
        chk("t6_count", 32'(fetch_count), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        repeat (5) begin
            cycle();
            chk("t6_idle_valid", 32'(if_valid), 32'd0);
            chk("t6_idle_addr", imem_addr, 32'd0);
        end

        // Random traffic against the model
        for (int i = 0; i < DEPTH; i++)
            mem[i] = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
        for (int c = 0; c < 3000; c++) begin
            rst_n           = ($urandom_range(99) != 0);
            start           = ($urandom_range(7) == 0);
            id_ready        = ($urandom_range(3) != 0);
            redirect_valid  = ($urandom_range(15) == 0);
            redirect_target = 32'($urandom_range(47));
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++)
                    mem[i] = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            end
            cycle();
        end
        rst_n          = 1'b1;
        start          = 1'b0;
        redirect_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
